vscale_fetch_redirect_ctrl: RTL

- Sequencer for the fetch-stage PC source multiplexer. Each cycle it picks the PC source select code from the competing redirect requests: exception handler, ERET/EPC, JALR, JAL, taken branch, IF-stage stall, and sequential fetch.
- The PC mux holds the current IF PC while imem_wait is high, which would drop any redirect raised during a memory wait. This block latches such a redirect's target and replays it once the wait clears.
- Sits between the pipeline control unit and the PC mux / IF PC register.

---
 rtl/vscale_fetch_redirect_ctrl_pkg.sv | 24 ++
 rtl/vscale_fetch_redirect_ctrl_prio.sv | 23 ++
 rtl/vscale_fetch_redirect_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/vscale_fetch_redirect_ctrl_pkg.sv
// vscale_fetch_redirect_ctrl_pkg: PC select codes, fetch FSM states and redirect ranks
package vscale_fetch_redirect_ctrl_pkg;
  localparam logic [2:0] PC_PLUS_FOUR = 3'd0;
  localparam logic [2:0] PC_BRANCH_TARGET = 3'd1;
  localparam logic [2:0] PC_JAL_TARGET = 3'd2;
  localparam logic [2:0] PC_JALR_TARGET = 3'd3;
  localparam logic [2:0] PC_REPLAY = 3'd4;
  localparam logic [2:0] PC_HANDLER = 3'd5;
  localparam logic [2:0] PC_EPC = 3'd6;
  typedef enum logic [1:0] {
    FETCH_ST_BOOT,
    FETCH_ST_RUN,
    FETCH_ST_PEND,
    FETCH_ST_APPLY
  } fetch_st_e;
  typedef enum logic [2:0] {
    RANK_NONE,
    RANK_BRANCH,
    RANK_JAL,
    RANK_JALR,
    RANK_EPC,
    RANK_EXC
  } rank_e;
endpackage

// File: rtl/vscale_fetch_redirect_ctrl_prio.sv
// vscale_redirect_prio: priority encoder from redirect requests to PC select, rank and any-redirect
module vscale_redirect_prio
  import vscale_fetch_redirect_ctrl_pkg::*;
(
  input  logic       exc_req,
  input  logic       eret_req,
  input  logic       jalr_req,
  input  logic       jal_req,
  input  logic       branch_taken,
  input  logic       stall_IF,
  output logic [2:0] pc_src_sel,
  output rank_e      rank,
  output logic       any_redirect
);
  always_comb begin
    rank = exc_req ? RANK_EXC : eret_req ? RANK_EPC : jalr_req ? RANK_JALR :
           jal_req ? RANK_JAL : branch_taken ? RANK_BRANCH : RANK_NONE;
    pc_src_sel = exc_req ? PC_HANDLER : eret_req ? PC_EPC : jalr_req ? PC_JALR_TARGET :
                 jal_req ? PC_JAL_TARGET : branch_taken ? PC_BRANCH_TARGET :
                 stall_IF ? PC_REPLAY : PC_PLUS_FOUR;
    any_redirect = rank != RANK_NONE;
  end
endmodule

// File: rtl/vscale_fetch_redirect_ctrl.sv
// vscale_fetch_redirect_ctrl: fetch PC source sequencer that holds redirects raised during imem waits
module vscale_fetch_redirect_ctrl
  import vscale_fetch_redirect_ctrl_pkg::*;
#(
  parameter int                 XPR_LEN          = 32,
  parameter int                 PC_SRC_SEL_WIDTH = 3,
  parameter logic [XPR_LEN-1:0] RESET_PC         = 'h200
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        exc_req,
  input  logic                        eret_req,
  input  logic                        jalr_req,
  input  logic                        jal_req,
  input  logic                        branch_taken,
  input  logic                        stall_IF,
  input  logic                        imem_wait,
  input  logic [XPR_LEN-1:0]          target_p,
  output logic [PC_SRC_SEL_WIDTH-1:0] PC_src_sel,
  output logic                        pc_override_valid,
  output logic [XPR_LEN-1:0]          pc_override,
  output logic                        kill_IF,
  output logic                        redirect_pending,
  output logic [7:0]                  redirect_drop_cnt
);
  fetch_st_e          state_q, state_d;
  rank_e              rank_q, rank_d, rank;
  logic [XPR_LEN-1:0] tgt_q, tgt_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [2:0]         sel;
  logic               any;
  vscale_redirect_prio u_prio (
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .jalr_req     (jalr_req),
    .jal_req      (jal_req),
    .branch_taken (branch_taken),
    .stall_IF     (stall_IF),
    .pc_src_sel   (sel),
    .rank         (rank),
    .any_redirect (any)
  );
  always_comb begin
    state_d = state_q;
    rank_d = rank_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    PC_src_sel = PC_SRC_SEL_WIDTH'(state_q == FETCH_ST_BOOT ? PC_REPLAY : sel);
    pc_override_valid = 1'b0;
    kill_IF = any;
    case (state_q)
      FETCH_ST_BOOT: begin
        pc_override_valid = 1'b1;
        kill_IF = 1'b1;
        state_d = imem_wait ? FETCH_ST_BOOT : FETCH_ST_RUN;
      end
      FETCH_ST_PEND: begin
        kill_IF = 1'b1;
        if (rank > rank_q) begin
          tgt_d = target_p;
          rank_d = rank;
        end
        if (rank > rank_q || exc_req) cnt_d = cnt_q + 8'(cnt_q != 8'hFF);
        state_d = imem_wait ? FETCH_ST_PEND : FETCH_ST_APPLY;
      end
      default: begin
        if (state_q == FETCH_ST_APPLY) begin
          pc_override_valid = !(any && !imem_wait);
          kill_IF = 1'b1;
        end
        if (any && imem_wait) begin
          tgt_d = target_p;
          rank_d = rank;
        end
        state_d = (any && imem_wait) ? FETCH_ST_PEND : FETCH_ST_RUN;
      end
    endcase
  end
  assign pc_override = tgt_q;
  assign redirect_pending = state_q == FETCH_ST_PEND;
  assign redirect_drop_cnt = cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH_ST_BOOT;
      rank_q <= RANK_NONE;
      tgt_q <= RESET_PC;
      cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      rank_q <= rank_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
